// File: rtl/mux_scan_serializer_pkg.sv
// ----------------------------------------------------------------------------
// ser_pkg: shared definitions for mux_scan_serializer.
//   - DATA_W / SEL_W: word width and select width (fixed at 8 / 3).
//   - state_t: FSM state encoding (IDLE, SHIFT, PAR). PAR is only reached
//     when the design is built with SER_PARITY_EN defined.
//   - first_idx / last_idx: start and final select index for a scan
//     direction (LSB_FIRST=1 counts 0->7, LSB_FIRST=0 counts 7->0).
// ----------------------------------------------------------------------------
package ser_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    function automatic logic [SEL_W-1:0] first_idx(input bit lsb_first);
        return lsb_first ? 3'd0 : 3'd7;
    endfunction

    function automatic logic [SEL_W-1:0] last_idx(input bit lsb_first);
        return lsb_first ? 3'd7 : 3'd0;
    endfunction

endpackage

// File: rtl/mux_scan_serializer_sel_step_counter.sv
// ----------------------------------------------------------------------------
// sel_step_counter: 3-bit up/down select counter.
//   Counts up when LSB_FIRST=1 and down otherwise. A synchronous load (or
//   reset) puts it back on the start index; en advances it by one step.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset (to the start index)
//   load  in   reload the start index
//   en    in   advance one step (a beat transferred)
//   q     out  current index
//   nxt   out  index after one step (combinational look-ahead of q)
//   tc    out  q is at the final index
// ----------------------------------------------------------------------------
module sel_step_counter
    import ser_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [SEL_W-1:0] q,
    output logic [SEL_W-1:0] nxt,
    output logic             tc
);

    localparam logic [SEL_W-1:0] FIRST_IDX = first_idx(LSB_FIRST);
    localparam logic [SEL_W-1:0] LAST_IDX  = last_idx(LSB_FIRST);

    assign nxt = LSB_FIRST ? q + 3'd1 : q - 3'd1;
    assign tc  = (q == LAST_IDX);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of the order of always blocks.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= FIRST_IDX;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/mux_scan_serializer.sv
// ----------------------------------------------------------------------------
// mux_scan_serializer: parallel-in / serial-out stage.
//   Accepts an 8-bit word on a valid/ready handshake, then walks a 3-bit
//   select index through all 8 positions, emitting one bit per accepted beat.
//   sel also drives the downstream 8:1 mux tree.
//   Optional macro SER_PARITY_EN: adds one trailing even-parity beat (PAR
//   state); out_last then flags the parity beat instead of the final data beat.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_data    in   parallel word [DATA_W-1:0]
//   in_valid   in   in_data is valid
//   in_ready   out  block can accept a word
//   sout       out  current serial bit
//   out_valid  out  sout is valid
//   out_ready  in   consumer takes sout this cycle
//   out_last   out  current beat is the final beat of the word
//   sel        out  current bit index / downstream mux select [2:0]
//   busy       out  a word is in flight
// All outputs are registered.
// ----------------------------------------------------------------------------
module mux_scan_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [SEL_W-1:0]  sel,
    output logic              busy
);

    localparam logic [SEL_W-1:0] FIRST_IDX = first_idx(LSB_FIRST);
    localparam logic [SEL_W-1:0] LAST_IDX  = last_idx(LSB_FIRST);

    state_t             state, state_n;
    logic [DATA_W-1:0]  hold;
    logic               hold_load;
    logic               cnt_load, cnt_en, cnt_tc;
    logic [SEL_W-1:0]   cnt_nxt;
    logic               in_ready_n, out_valid_n, busy_n, sout_n, out_last_n;
    logic               xfer;

    assign xfer = out_valid && out_ready;

    sel_step_counter #(
        .LSB_FIRST (LSB_FIRST)
    ) u_sel_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .q    (sel),
        .nxt  (cnt_nxt),
        .tc   (cnt_tc)
    );

    // NOTE: the hold register is pure datapath: it is only read while busy and
    // is always loaded before use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (hold_load) begin
            hold <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sout      <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
            sout      <= sout_n;
            out_last  <= out_last_n;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        in_ready_n  = in_ready;
        out_valid_n = out_valid;
        busy_n      = busy;
        sout_n      = sout;
        out_last_n  = out_last;
        hold_load   = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;

        case (state)
            IDLE: begin
                // rst gates hold_load so a word presented alongside reset is
                // not captured.
                if (in_valid && in_ready && !rst) begin
                    hold_load   = 1'b1;
                    state_n     = SHIFT;
                    in_ready_n  = 1'b0;
                    out_valid_n = 1'b1;
                    busy_n      = 1'b1;
                    sout_n      = in_data[FIRST_IDX];
                    out_last_n  = 1'b0;
                end
            end

            SHIFT: begin
                if (xfer) begin
                    if (cnt_tc) begin
`ifdef SER_PARITY_EN
                        // sel stays parked on the final index during PAR.
                        state_n    = PAR;
                        sout_n     = ^hold;
                        out_last_n = 1'b1;
`else
                        state_n     = IDLE;
                        cnt_load    = 1'b1;
                        in_ready_n  = 1'b1;
                        out_valid_n = 1'b0;
                        busy_n      = 1'b0;
                        sout_n      = 1'b0;
                        out_last_n  = 1'b0;
`endif
                    end else begin
                        cnt_en = 1'b1;
                        // Look ahead through the 8:1 mux with the stepped index
                        // so sout and sel change on the same edge.
                        sout_n = hold[cnt_nxt];
`ifdef SER_PARITY_EN
                        out_last_n = 1'b0;
`else
                        out_last_n = (cnt_nxt == LAST_IDX);
`endif
                    end
                end
            end

`ifdef SER_PARITY_EN
            PAR: begin
                if (xfer) begin
                    state_n     = IDLE;
                    cnt_load    = 1'b1;
                    in_ready_n  = 1'b1;
                    out_valid_n = 1'b0;
                    busy_n      = 1'b0;
                    sout_n      = 1'b0;
                    out_last_n  = 1'b0;
                end
            end
`endif

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// ----------------------------------------------------------------------------
// tb_mux_scan_serializer: bench for mux_scan_serializer.
// Two instances share all inputs: u_lsb (LSB_FIRST=1) and u_msb (LSB_FIRST=0).
// A transaction-level model (busy flag, held word, beat number) predicts both
// every cycle; a vector table and hand sequences add fixed expectations.
// ----------------------------------------------------------------------------
module tb_mux_scan_serializer;

`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    // out_last on the final data beat only when there is no parity beat.
    localparam logic LD = (NB == 8);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       l_in_ready, l_sout, l_out_valid, l_out_last, l_busy;
    logic [2:0] l_sel;
    logic       m_in_ready, m_sout, m_out_valid, m_out_last, m_busy;
    logic [2:0] m_sel;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    logic       md_busy = 1'b0;
    logic [7:0] md_word = 8'h00;
    int         md_k = 0;

    always #5 clk = ~clk;

    mux_scan_serializer #(.DATA_W(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_in_ready), .sout(l_sout), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_last(l_out_last), .sel(l_sel), .busy(l_busy)
    );

    mux_scan_serializer #(.DATA_W(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(m_in_ready), .sout(m_sout), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_last(m_out_last), .sel(m_sel), .busy(m_busy)
    );

    typedef struct {
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       e_ready;
        logic       e_valid;
        logic       e_sout;
        logic [2:0] e_sel;
        logic       e_last;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model advance at a clock edge, from the inputs seen at that edge.
    task automatic model_edge();
        if (rst) begin
            md_busy = 1'b0;
        end else if (!md_busy) begin
            if (in_valid) begin
                md_busy = 1'b1;
                md_word = in_data;
                md_k    = 0;
            end
        end else if (out_ready) begin
            if (md_k == NB - 1) md_busy = 1'b0;
            else                md_k++;
        end
    endtask

    task automatic model_check(input bit lsb, input string tag,
                               input logic a_ready, input logic a_valid, input logic a_busy,
                               input logic [2:0] a_sel, input logic a_sout, input logic a_last);
        int  pos;
        logic [2:0] e_sel;
        logic e_sout;
        pos   = (md_k > 7) ? 7 : md_k;
        e_sel = !md_busy ? (lsb ? 3'd0 : 3'd7) : (lsb ? 3'(pos) : 3'(7 - pos));
        e_sout = (md_k < 8) ? md_word[e_sel] : ^md_word;
        check({tag, ".in_ready"},  {7'd0, a_ready}, {7'd0, !md_busy});
        check({tag, ".out_valid"}, {7'd0, a_valid}, {7'd0, md_busy});
        check({tag, ".busy"},      {7'd0, a_busy},  {7'd0, md_busy});
        check({tag, ".sel"},       {5'd0, a_sel},   {5'd0, e_sel});
        check({tag, ".out_last"},  {7'd0, a_last},  {7'd0, md_busy && (md_k == NB - 1)});
        if (md_busy) check({tag, ".sout"}, {7'd0, a_sout}, {7'd0, e_sout});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        model_check(1'b1, "lsb", l_in_ready, l_out_valid, l_busy, l_sel, l_sout, l_out_last);
        model_check(1'b0, "msb", m_in_ready, m_out_valid, m_busy, m_sel, m_sout, m_out_last);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Basic A5, LSB first, out_ready=1: accept row, then 7 transfers.
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, LD};

        // Reset state.
        rst = 1'b1;
        ticks(2);
        check("rst.l_sel", {5'd0, l_sel}, 8'd0);
        check("rst.m_sel", {5'd0, m_sel}, 8'd7);
        check("rst.l_in_ready", {7'd0, l_in_ready}, 8'd1);
        check("rst.l_out_valid", {7'd0, l_out_valid}, 8'd0);
        check("rst.l_sout", {7'd0, l_sout}, 8'd0);
        check("rst.m_out_last", {7'd0, m_out_last}, 8'd0);
        rst = 1'b0;
        tick();

        // Table-driven basic word.
        for (int i = 0; i < 8; i++) begin
            in_valid  = tbl[i].in_valid;
            in_data   = tbl[i].in_data;
            out_ready = tbl[i].out_ready;
            tick();
            check($sformatf("tbl%0d.in_ready", i),  {7'd0, l_in_ready},  {7'd0, tbl[i].e_ready});
            check($sformatf("tbl%0d.out_valid", i), {7'd0, l_out_valid}, {7'd0, tbl[i].e_valid});
            check($sformatf("tbl%0d.sout", i),      {7'd0, l_sout},      {7'd0, tbl[i].e_sout});
            check($sformatf("tbl%0d.sel", i),       {5'd0, l_sel},       {5'd0, tbl[i].e_sel});
            check($sformatf("tbl%0d.out_last", i),  {7'd0, l_out_last},  {7'd0, tbl[i].e_last});
        end
        ticks(NB - 7);
        check("a5.idle_in_ready", {7'd0, l_in_ready}, 8'd1);
        check("a5.idle_out_valid", {7'd0, l_out_valid}, 8'd0);

        // Backpressure: 3C, out_ready low during cycles 3..5 after accept.
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 11 + NB - 8; c++) begin
            out_ready = (c < 3 || c > 5);
            tick();
            if (c >= 3 && c <= 5) begin
                check("bp.l_sel", {5'd0, l_sel}, 8'd2);
                check("bp.l_sout", {7'd0, l_sout}, 8'd1);
                check("bp.l_out_valid", {7'd0, l_out_valid}, 8'd1);
            end
        end
        out_ready = 1'b1;
        check("bp.done_in_ready", {7'd0, l_in_ready}, 8'd1);
        tick();

        // MSB first on u_msb: 81.
        in_valid = 1'b1; in_data = 8'h81;
        tick();
        in_valid = 1'b0;
        check("msb81.first_sel", {5'd0, m_sel}, 8'd7);
        check("msb81.first_sout", {7'd0, m_sout}, 8'd1);
        ticks(7);
        check("msb81.last_sel", {5'd0, m_sel}, 8'd0);
        check("msb81.last_sout", {7'd0, m_sout}, 8'd1);
        check("msb81.last_flag", {7'd0, m_out_last}, {7'd0, LD});
        ticks(NB - 7);

        // Back-to-back: FF then 00 with in_valid held high.
        in_valid = 1'b1; in_data = 8'hFF;
        tick();
        in_data = 8'h00;
        ticks(NB);
        check("b2b.gap_in_ready", {7'd0, l_in_ready}, 8'd1);
        check("b2b.gap_out_valid", {7'd0, l_out_valid}, 8'd0);
        tick();
        in_valid = 1'b0;
        check("b2b.second_sout", {7'd0, l_sout}, 8'd0);
        check("b2b.second_sel", {5'd0, l_sel}, 8'd0);
        ticks(NB);

        // Reset after the 3rd beat of F0, then reset together with in_valid.
        in_valid = 1'b1; in_data = 8'hF0;
        tick();
        in_valid = 1'b0;
        ticks(3);
        rst = 1'b1;
        tick();
        check("rstmid.out_valid", {7'd0, l_out_valid}, 8'd0);
        check("rstmid.in_ready", {7'd0, l_in_ready}, 8'd1);
        check("rstmid.sel", {5'd0, l_sel}, 8'd0);
        in_valid = 1'b1; in_data = 8'h0F;
        tick();
        check("rstvalid.not_taken", {7'd0, l_out_valid}, 8'd0);
        rst = 1'b0;
        tick();
        in_valid = 1'b0;
        check("after_rst.sout0", {7'd0, l_sout}, 8'd1);
        ticks(NB);

`ifdef SER_PARITY_EN
        // Parity beats: 07 -> 1, 03 -> 0.
        in_valid = 1'b1; in_data = 8'h07;
        tick();
        in_valid = 1'b0;
        ticks(8);
        check("par07.sout", {7'd0, l_sout}, 8'd1);
        check("par07.last", {7'd0, l_out_last}, 8'd1);
        check("par07.sel", {5'd0, l_sel}, 8'd7);
        tick();
        in_valid = 1'b1; in_data = 8'h03;
        tick();
        in_valid = 1'b0;
        ticks(8);
        check("par03.sout", {7'd0, l_sout}, 8'd0);
        check("par03.last", {7'd0, l_out_last}, 8'd1);
        tick();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ticks(NB + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
